count_sequence_checker: RTL and testbench

- Passive monitor on the output side of an up/down counter. It samples count_i and up_down_i and checks that each new sample equals the previous sample ±1, as set by the direction in force at the previous sample.
- Reports lock status, mismatch errors and wrap-around events.
- Sits beside any parameterized counter instance, in RTL self-check or in the bench, with no feedback into the counter.

---
 rtl/count_sequence_checker.sv | 147 ++++++++++++++
 tb/tb_count_sequence_checker.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/count_sequence_checker.sv
// Passive monitor for an up/down counter: checks each sample is prev +/- 1, tracks lock, errors and wraps.
// Optional hold tolerance (repeated value is not a mismatch) is enabled by defining COUNT_CHECK_HOLD_EN.
module count_sequence_checker #(
  parameter int WIDTH      = 16,
  parameter int LOCK_LEN   = 4,
  parameter int STAT_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  sample_en_i,
  input  logic [WIDTH-1:0]      count_i,
  input  logic                  up_down_i,
  input  logic                  clear_i,
  output logic                  locked_o,
  output logic                  error_o,
  output logic [STAT_WIDTH-1:0] err_count_o,
  output logic [STAT_WIDTH-1:0] wrap_count_o,
  output logic [WIDTH-1:0]      expected_o,
`ifdef COUNT_CHECK_HOLD_EN
  output logic                  hold_o,
`endif
  output logic [1:0]            state_o
);

  // Handshake: sample_en_i qualifies count_i/up_down_i for exactly the cycle it is high;
  // there is no ready, the monitor accepts every qualified sample.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic [7:0] LP_LOCK_LEN = 8'(LOCK_LEN);

  state_t                r_state;
  logic [WIDTH-1:0]      r_prev;
  logic                  r_dir;
  logic [7:0]            r_run;
  logic                  r_locked;
  logic                  r_error;
  logic [STAT_WIDTH-1:0] r_err_count;
  logic [STAT_WIDTH-1:0] r_wrap_count;
  logic [WIDTH-1:0]      r_expected;
`ifdef COUNT_CHECK_HOLD_EN
  logic                  r_hold;
  logic                  w_hold;
`endif

  logic             w_good;
  logic             w_wrap;
  logic [WIDTH-1:0] w_next_exp;
  logic [7:0]       w_run_inc;
  logic             w_run_done;

  // r_expected always equals the step target derived from r_prev/r_dir
  assign w_good     = (count_i == r_expected);
  assign w_wrap     = w_good & (r_dir ? (&r_prev) : ~(|r_prev));
  assign w_next_exp = up_down_i ? (count_i + WIDTH'(1)) : (count_i - WIDTH'(1));
  assign w_run_inc  = r_run + 8'd1;
  assign w_run_done = (w_run_inc == LP_LOCK_LEN);
`ifdef COUNT_CHECK_HOLD_EN
  assign w_hold     = (count_i == r_prev);
`endif

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_state      <= IDLE;
      r_prev       <= '0;
      r_dir        <= 1'b0;
      r_run        <= '0;
      r_locked     <= 1'b0;
      r_error      <= 1'b0;
      r_err_count  <= '0;
      r_wrap_count <= '0;
      r_expected   <= '0;
`ifdef COUNT_CHECK_HOLD_EN
      r_hold       <= 1'b0;
`endif
    end else if (clear_i) begin
      r_state      <= IDLE;
      r_run        <= '0;
      r_locked     <= 1'b0;
      r_error      <= 1'b0;
      r_err_count  <= '0;
      r_wrap_count <= '0;
`ifdef COUNT_CHECK_HOLD_EN
      r_hold       <= 1'b0;
`endif
    end else begin
      r_error <= 1'b0;
`ifdef COUNT_CHECK_HOLD_EN
      r_hold  <= 1'b0;
`endif
      if (sample_en_i) begin
        // context always reloads, so a resync after a mismatch needs no extra path
        r_prev     <= count_i;
        r_dir      <= up_down_i;
        r_expected <= w_next_exp;
        case (r_state)
          IDLE: begin
            r_state <= ACQUIRE;
            r_run   <= '0;
          end
          ACQUIRE, LOCKED: begin
            if (w_good) begin
              if (w_wrap && !(&r_wrap_count)) r_wrap_count <= r_wrap_count + 1'b1;
              if (r_state == ACQUIRE) begin
                r_run <= w_run_inc;
                if (w_run_done) begin
                  r_state  <= LOCKED;
                  r_locked <= 1'b1;
                end
              end
`ifdef COUNT_CHECK_HOLD_EN
            end else if (w_hold) begin
              r_hold <= 1'b1;
`endif
            end else begin
              r_run <= '0;
              if (r_state == LOCKED) begin
                r_error  <= 1'b1;
                r_state  <= ACQUIRE;
                r_locked <= 1'b0;
                if (!(&r_err_count)) r_err_count <= r_err_count + 1'b1;
              end
            end
          end
          default: begin
            r_state  <= IDLE;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  assign locked_o     = r_locked;
  assign error_o      = r_error;
  assign err_count_o  = r_err_count;
  assign wrap_count_o = r_wrap_count;
  assign expected_o   = r_expected;
  assign state_o      = r_state;
`ifdef COUNT_CHECK_HOLD_EN
  assign hold_o       = r_hold;
`endif

endmodule

// File: tb/tb_count_sequence_checker.sv
// Self-checking bench for count_sequence_checker: directed scenarios plus random stimulus
// against an integer-level model of the step/lock rules. Honours COUNT_CHECK_HOLD_EN.
module tb_count_sequence_checker;

  localparam int W    = 16;
  localparam int LL   = 4;
  localparam int SW   = 8;
  localparam int MAXV = (1 << W) - 1;
  localparam int SMAX = (1 << SW) - 1;
  localparam int EW   = W + 2 * SW + 4;
`ifdef COUNT_CHECK_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          sample_en_i;
  logic [W-1:0]  count_i;
  logic          up_down_i;
  logic          clear_i;
  logic          locked_o;
  logic          error_o;
  logic [SW-1:0] err_count_o;
  logic [SW-1:0] wrap_count_o;
  logic [W-1:0]  expected_o;
  logic          hold_o;
  logic [1:0]    state_o;

  int n_checks = 0;
  int n_fail   = 0;

  // clock / reset
  always #5 clk_i = ~clk_i;

  count_sequence_checker #(.WIDTH(W), .LOCK_LEN(LL), .STAT_WIDTH(SW)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .sample_en_i  (sample_en_i),
    .count_i      (count_i),
    .up_down_i    (up_down_i),
    .clear_i      (clear_i),
    .locked_o     (locked_o),
    .error_o      (error_o),
    .err_count_o  (err_count_o),
    .wrap_count_o (wrap_count_o),
    .expected_o   (expected_o),
`ifdef COUNT_CHECK_HOLD_EN
    .hold_o       (hold_o),
`endif
    .state_o      (state_o)
  );
`ifndef COUNT_CHECK_HOLD_EN
  assign hold_o = 1'b0;
`endif

  // reference model: mode 0 idle, 1 acquiring, 2 locked
  int m_mode, m_prev, m_dir, m_run, m_err, m_wrap, m_exp;
  bit m_error, m_hold;

  function automatic void model_step(bit rst, bit clr, bit en, int cnt, bit ud);
    int  want;
    bit  is_wrap;
    m_error = 1'b0;
    m_hold  = 1'b0;
    if (!rst) begin
      m_mode = 0; m_prev = 0; m_dir = 0; m_run = 0; m_err = 0; m_wrap = 0; m_exp = 0;
    end else if (clr) begin
      m_mode = 0; m_run = 0; m_err = 0; m_wrap = 0;
    end else if (en) begin
      if (m_mode == 0) begin
        m_mode = 1;
        m_run  = 0;
      end else begin
        want    = (m_prev + (m_dir != 0 ? 1 : MAXV)) % (MAXV + 1);
        is_wrap = (m_dir != 0 && m_prev == MAXV) || (m_dir == 0 && m_prev == 0);
        if (cnt == want) begin
          if (is_wrap && m_wrap < SMAX) m_wrap++;
          if (m_mode == 1) begin
            m_run++;
            if (m_run == LL) m_mode = 2;
          end
        end else if (HOLD && cnt == m_prev) begin
          m_hold = 1'b1;
        end else begin
          if (m_mode == 2) begin
            m_error = 1'b1;
            if (m_err < SMAX) m_err++;
          end
          m_run  = 0;
          m_mode = 1;
        end
      end
      m_prev = cnt;
      m_dir  = ud;
      m_exp  = (cnt + (ud ? 1 : MAXV)) % (MAXV + 1);
    end
  endfunction

  // scoreboard
  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_i) begin
    logic [EW-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("locked_o",     32'(locked_o),     32'(e[W+2*SW+2]));
      check("error_o",      32'(error_o),      32'(e[W+2*SW+1]));
      check("err_count_o",  32'(err_count_o),  32'(e[W+2*SW-1:W+SW]));
      check("wrap_count_o", 32'(wrap_count_o), 32'(e[W+SW-1:W]));
      if (HOLD) check("hold_o", 32'(hold_o), 32'(e[W+2*SW]));
      if (e[W+2*SW+3]) check("expected_o", 32'(expected_o), 32'(e[W-1:0]));
    end
  end

  // driver tasks
  task automatic tick(input bit rst, input bit clr, input bit en, input int cnt, input bit ud);
    reset_i     = rst;
    clear_i     = clr;
    sample_en_i = en;
    count_i     = cnt[W-1:0];
    up_down_i   = ud;
    @(posedge clk_i);
    model_step(rst, clr, en, cnt, ud);
    exp_q.push_back({m_mode != 0, m_mode == 2, m_error, m_hold,
                     SW'(m_err), SW'(m_wrap), W'(m_exp)});
    @(negedge clk_i);
    #1;
  endtask

  task automatic samp(input int cnt, input bit ud);
    tick(1'b1, 1'b0, 1'b1, cnt, ud);
  endtask

  task automatic up_seq(input int start, input int n);
    for (int i = 0; i < n; i++) samp((start + i) % (MAXV + 1), 1'b1);
  endtask

  initial begin
    int v;
    bit ud;
    int r, cnt;
    reset_i = 1'b0; clear_i = 1'b0; sample_en_i = 1'b0; count_i = '0; up_down_i = 1'b0;
    tick(1'b0, 1'b0, 1'b0, 0, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 77, 1'b1);
    check("rst_locked",   32'(locked_o),     32'd0);
    check("rst_error",    32'(error_o),      32'd0);
    check("rst_errcnt",   32'(err_count_o),  32'd0);
    check("rst_wrapcnt",  32'(wrap_count_o), 32'd0);
    check("rst_expected", 32'(expected_o),   32'd0);

    // lock on an up count from 0
    up_seq(0, 4);
    check("not_locked_at_3", 32'(locked_o), 32'd0);
    samp(4, 1'b1);
    check("locked_at_4", 32'(locked_o), 32'd1);
    up_seq(5, 46);
    check("expected_51", 32'(expected_o), 32'd51);
    samp(100, 1'b1);
    check("inject_error",  32'(error_o),     32'd1);
    check("inject_errcnt", 32'(err_count_o), 32'd1);
    check("inject_unlock", 32'(locked_o),    32'd0);
    up_seq(101, 4);
    check("relock_104", 32'(locked_o), 32'd1);

    // wrap up through all-ones, then down through zero
    tick(1'b1, 1'b1, 1'b1, 9, 1'b1);
    up_seq(65530, 7);
    check("wrap_up",        32'(wrap_count_o), 32'd1);
    check("wrap_up_locked", 32'(locked_o),     32'd1);
    samp(1, 1'b0);
    samp(0, 1'b0);
    samp(65535, 1'b0);
    check("wrap_down",       32'(wrap_count_o), 32'd2);
    check("wrap_down_noerr", 32'(err_count_o),  32'd0);

    // disabled cycles carrying garbage are ignored
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b0, $urandom_range(0, MAXV), 1'($urandom));
    samp(65534, 1'b0);
    check("gap_locked", 32'(locked_o), 32'd1);

    // clear mid-LOCKED, relock after 1 + LL samples
    tick(1'b1, 1'b1, 1'b1, 5, 1'b1);
    check("clr_locked", 32'(locked_o),     32'd0);
    check("clr_wrap",   32'(wrap_count_o), 32'd0);
    up_seq(200, LL + 1);
    check("clr_relock", 32'(locked_o), 32'd1);

    // three errors, then reset
    v = 204;
    for (int k = 0; k < 3; k++) begin
      v = v + 50;
      samp(v, 1'b1);
      up_seq(v + 1, LL);
      v = v + LL;
    end
    check("err_three", 32'(err_count_o), 32'd3);
    tick(1'b0, 1'b0, 1'b1, 3, 1'b1);
    check("rst2_locked",   32'(locked_o),     32'd0);
    check("rst2_errcnt",   32'(err_count_o),  32'd0);
    check("rst2_expected", 32'(expected_o),   32'd0);

    // repeated value from LOCKED
    up_seq(5, 6);
    samp(11, 1'b1);
    samp(11, 1'b1);
    if (HOLD) begin
      check("hold_pulse", 32'(hold_o),  32'd1);
      check("hold_noerr", 32'(error_o), 32'd0);
    end else begin
      check("repeat_error", 32'(error_o), 32'd1);
    end
    samp(12, 1'b1);

    // drive err_count_o into saturation
    v = 12;
    for (int k = 0; k < SMAX + 20; k++) begin
      v = (v + 1000) % (MAXV + 1);
      samp(v, 1'b1);
      up_seq((v + 1) % (MAXV + 1), LL);
      v = (v + LL) % (MAXV + 1);
    end
    check("err_saturate", 32'(err_count_o), 32'(SMAX));

    // random traffic against the model
    ud = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 9) == 0) ud = ~ud;
      if (r < 85)      cnt = (m_prev + (m_dir != 0 ? 1 : MAXV)) % (MAXV + 1);
      else if (r < 92) cnt = m_prev;
      else             cnt = $urandom_range(0, MAXV);
      if ($urandom_range(0, 29) == 0) cnt = $urandom_range(MAXV - 2, MAXV);
      tick($urandom_range(0, 199) != 0, $urandom_range(0, 99) == 0,
           $urandom_range(0, 9) < 8, cnt, ud);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
